mc_cpu: RTL and testbench

MC_CPU -- requirements
Module: mc_cpu

---
 rtl/mc_cpu_pkg.sv | 60 ++++++
 rtl/mc_cpu_alu.sv | 98 +++++++++
 rtl/mc_cpu.sv | 135 +++++++++++++
 tb/tb_mc_cpu.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: opcodes, FSM state type and instruction field layout shared by mc_cpu.
// Optional feature: define MC_CPU_MUL_EN to make op 13 (MUL) a legal instruction.
package mc_cpu_pkg;

    // Instruction field positions within the 32-bit instruction word
    localparam int unsigned OpLsb  = 0;
    localparam int unsigned RaLsb  = 6;
    localparam int unsigned RbLsb  = 9;
    localparam int unsigned RdLsb  = 12;
    localparam int unsigned HlBit  = 15;
    localparam int unsigned ImmLsb = 16;

    localparam logic [5:0] OpNop   = 6'd0;
    localparam logic [5:0] OpAdd   = 6'd1;
    localparam logic [5:0] OpSub   = 6'd2;
    localparam logic [5:0] OpAnd   = 6'd3;
    localparam logic [5:0] OpOr    = 6'd4;
    localparam logic [5:0] OpXor   = 6'd5;
    localparam logic [5:0] OpLdi   = 6'd6;
    localparam logic [5:0] OpSt    = 6'd7;
    localparam logic [5:0] OpLd    = 6'd8;
    localparam logic [5:0] OpJmp   = 6'd9;
    localparam logic [5:0] OpBrf   = 6'd10;
    localparam logic [5:0] OpCmpeq = 6'd11;
    localparam logic [5:0] OpCmplt = 6'd12;
    localparam logic [5:0] OpMul   = 6'd13;
    localparam logic [5:0] OpHalt  = 6'd63;

    typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

    typedef struct packed {
        logic [15:0] imm;
        logic        hl;
        logic [2:0]  rd;
        logic [2:0]  rb;
        logic [2:0]  ra;
        logic [5:0]  op;
    } instr_t;

    function automatic instr_t decode(input logic [31:0] word);
        instr_t d;
        d.op  = word[OpLsb +: 6];
        d.ra  = word[RaLsb +: 3];
        d.rb  = word[RbLsb +: 3];
        d.rd  = word[RdLsb +: 3];
        d.hl  = word[HlBit];
        d.imm = word[ImmLsb +: 16];
        return d;
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        legal = (op <= OpCmplt) || (op == OpHalt);
`ifdef MC_CPU_MUL_EN
        legal = legal || (op == OpMul);
`endif
        return legal;
    endfunction

endpackage

// File: rtl/mc_cpu_alu.sv
// mc_cpu_alu: combinational datapath producing the rd result and the fd flag for one instruction.
// With MC_CPU_MUL_EN defined, op 13 computes the low half of a*b and flags a non-zero high half.
module mc_cpu_alu
    import mc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [5:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] rd_old_i,
    input  logic [15:0]       imm_i,
    input  logic              hl_i,
    output logic [DATA_W-1:0] result_o,
    output logic              flag_o,
    output logic              wr_rd_o,
    output logic              wr_flag_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // Extra top bit carries the carry-out / borrow
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

`ifdef MC_CPU_MUL_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
`endif

    // Decode the opcode into a result, a flag and their write enables
    always_comb begin
        result_o  = '0;
        flag_o    = 1'b0;
        wr_rd_o   = 1'b0;
        wr_flag_o = 1'b0;
        case (op_i)
            OpAdd: begin
                result_o  = sum[DATA_W-1:0];
                flag_o    = sum[DATA_W];
                wr_rd_o   = 1'b1;
                wr_flag_o = 1'b1;
            end
            OpSub: begin
                result_o  = diff[DATA_W-1:0];
                flag_o    = diff[DATA_W];
                wr_rd_o   = 1'b1;
                wr_flag_o = 1'b1;
            end
            OpAnd: begin
                result_o  = a_i & b_i;
                flag_o    = ((a_i & b_i) == '0);
                wr_rd_o   = 1'b1;
                wr_flag_o = 1'b1;
            end
            OpOr: begin
                result_o  = a_i | b_i;
                flag_o    = ((a_i | b_i) == '0);
                wr_rd_o   = 1'b1;
                wr_flag_o = 1'b1;
            end
            OpXor: begin
                result_o  = a_i ^ b_i;
                flag_o    = ((a_i ^ b_i) == '0);
                wr_rd_o   = 1'b1;
                wr_flag_o = 1'b1;
            end
            OpLdi: begin
                if (hl_i) begin
                    result_o         = rd_old_i;
                    result_o[31:16]  = imm_i;
                end else begin
                    result_o = DATA_W'(imm_i);
                end
                wr_rd_o = 1'b1;
            end
            OpCmpeq: begin
                flag_o    = (a_i == b_i);
                wr_flag_o = 1'b1;
            end
            OpCmplt: begin
                flag_o    = (a_i < b_i);
                wr_flag_o = 1'b1;
            end
`ifdef MC_CPU_MUL_EN
            OpMul: begin
                result_o  = prod[DATA_W-1:0];
                flag_o    = (prod[2*DATA_W-1:DATA_W] != '0);
                wr_rd_o   = 1'b1;
                wr_flag_o = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle FETCH -> EXEC (-> MEM) CPU with 8 registers, 8 flags and a ready-based bus.
// Optional feature: MC_CPU_MUL_EN enables the MUL instruction (op 13) in mc_cpu_alu.
module mc_cpu
    import mc_cpu_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              illegal
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] rf_q [8];
    logic [7:0]        flag_q;
    instr_t            ir_q;

    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] alu_res;
    logic              alu_flag;
    logic              alu_wr_rd;
    logic              alu_wr_flag;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_exec;

    // Operands come from the register file before any writeback of this instruction
    assign a_val  = rf_q[ir_q.ra];
    assign b_val  = rf_q[ir_q.rb];
    assign rd_val = rf_q[ir_q.rd];
    assign pc_inc = pc_q + ADDR_W'(1);

    mc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i      (ir_q.op),
        .a_i       (a_val),
        .b_i       (b_val),
        .rd_old_i  (rd_val),
        .imm_i     (ir_q.imm),
        .hl_i      (ir_q.hl),
        .result_o  (alu_res),
        .flag_o    (alu_flag),
        .wr_rd_o   (alu_wr_rd),
        .wr_flag_o (alu_wr_flag)
    );

    // Next pc for instructions that leave EXEC straight back to FETCH
    always_comb begin
        pc_exec = pc_inc;
        if (ir_q.op == OpJmp || (ir_q.op == OpBrf && flag_q[ir_q.ra])) begin
            pc_exec = ADDR_W'(ir_q.imm);
        end
    end

    // Control FSM with registered bus outputs; the next fetch is issued on leaving EXEC/MEM
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            flag_q    <= '0;
            ir_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state_q)
                StFetch: begin
                    if (!mem_req) begin
                        // Only reached right after reset
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_q;
                    end else if (mem_ready) begin
                        ir_q    <= decode(mem_rdata[31:0]);
                        illegal <= !op_is_legal(mem_rdata[5:0]);
                        mem_req <= 1'b0;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (alu_wr_rd) rf_q[ir_q.rd] <= alu_res;
                    if (alu_wr_flag) flag_q[ir_q.rd] <= alu_flag;
                    if (ir_q.op == OpLd || ir_q.op == OpSt) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (ir_q.op == OpSt);
                        mem_addr  <= ADDR_W'(a_val);
                        mem_wdata <= b_val;
                        state_q   <= StMem;
                    end else if (ir_q.op == OpHalt) begin
                        halted  <= 1'b1;
                        state_q <= StHalt;
                    end else begin
                        pc_q     <= pc_exec;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_exec;
                        state_q  <= StFetch;
                    end
                end
                StMem: begin
                    if (mem_ready) begin
                        if (ir_q.op == OpLd) rf_q[ir_q.rd] <= mem_rdata;
                        pc_q     <= pc_inc;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_inc;
                        state_q  <= StFetch;
                    end
                end
                StHalt: begin
                    halted <= 1'b1;
                end
                default: state_q <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: directed and random instruction stream against an instruction-level reference model.
// Register and flag state is observed only through the bus (ST data/address, BRF fetch target).
module tb_mc_cpu;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h10;

  logic              clock;
  logic              reset;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              halted;
  logic              illegal;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_r [8];
  logic [7:0]  m_f;
  logic [31:0] m_pc;
  logic [31:0] m_dmem [logic [31:0]];
  int          exp_mem;  // 0 none, 1 store, 2 load
  logic        exp_illegal;
  logic        exp_halt;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  int          ld_rd;

  mc_cpu #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic ok, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (ok !== 1'b1) begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int ra, input int rb,
                                      input int hl, input int imm);
    logic [31:0] w;
    w        = '0;
    w[5:0]   = 6'(op);
    w[8:6]   = 3'(ra);
    w[11:9]  = 3'(rb);
    w[14:12] = 3'(rd);
    w[15]    = 1'(hl);
    w[31:16] = 16'(imm);
    return w;
  endfunction

  task automatic model_reset();
    foreach (m_r[i]) m_r[i] = '0;
    m_f  = '0;
    m_pc = RESET_PC;
  endtask

  // Instruction-level semantics; LD's register write is applied when the data arrives
  task automatic model_exec(input logic [31:0] ins);
    int          op;
    int          ra;
    int          rb;
    int          rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [15:0] imm;
    logic [63:0] wide;
    logic [31:0] nxt;
    op  = int'(ins[5:0]);
    ra  = int'(ins[8:6]);
    rb  = int'(ins[11:9]);
    rd  = int'(ins[14:12]);
    imm = ins[31:16];
    a   = m_r[ra];
    b   = m_r[rb];
    nxt = m_pc + 32'd1;
    exp_mem     = 0;
    exp_illegal = 1'b0;
    exp_halt    = 1'b0;
    case (op)
      0: ;
      1: begin
        wide    = 64'(a) + 64'(b);
        m_r[rd] = wide[31:0];
        m_f[rd] = (wide > 64'hFFFF_FFFF);
      end
      2: begin m_r[rd] = a - b; m_f[rd] = (a < b); end
      3: begin r = a & b; m_r[rd] = r; m_f[rd] = (r == 0); end
      4: begin r = a | b; m_r[rd] = r; m_f[rd] = (r == 0); end
      5: begin r = a ^ b; m_r[rd] = r; m_f[rd] = (r == 0); end
      6: begin
        r       = m_r[rd];
        m_r[rd] = ins[15] ? {imm, r[15:0]} : {16'h0, imm};
      end
      7: begin exp_mem = 1; exp_addr = a; exp_wdata = b; m_dmem[a] = b; end
      8: begin exp_mem = 2; exp_addr = a; ld_rd = rd; end
      9: nxt = {16'h0, imm};
      10: if (m_f[ra]) nxt = {16'h0, imm};
      11: m_f[rd] = (a == b);
      12: m_f[rd] = (a < b);
      13: begin
`ifdef MC_CPU_MUL_EN
        wide    = 64'(a) * 64'(b);
        m_r[rd] = wide[31:0];
        m_f[rd] = (wide[63:32] != 0);
`else
        exp_illegal = 1'b1;
`endif
      end
      63: exp_halt = 1'b1;
      default: exp_illegal = 1'b1;
    endcase
    if (!exp_halt) m_pc = nxt;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("req_seen", mem_req === 1'b1, mem_req, 1'b1);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_req", mem_req === 1'b0, mem_req, 1'b0);
    chk("rst_we", mem_we === 1'b0, mem_we, 1'b0);
    chk("rst_addr", mem_addr === 32'h0, mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata === 32'h0, mem_wdata, 32'h0);
    chk("rst_halted", halted === 1'b0, halted, 1'b0);
    chk("rst_illegal", illegal === 1'b0, illegal, 1'b0);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic fetch(input logic [31:0] ins, input int waits);
    logic [31:0] a0;
    wait_req();
    chk("fetch_addr", mem_addr === m_pc, mem_addr, m_pc);
    chk("fetch_we", mem_we === 1'b0, mem_we, 1'b0);
    a0 = mem_addr;
    for (int w = 0; w < waits; w++) begin
      @(negedge clock);
      chk("fetch_hold_req", mem_req === 1'b1, mem_req, 1'b1);
      chk("fetch_hold_addr", mem_addr === a0, mem_addr, a0);
    end
    mem_ready = 1'b1;
    mem_rdata = ins;
    @(negedge clock);
    mem_ready = 1'b0;
    mem_rdata = $urandom();
    model_exec(ins);
    chk("exec_req_low", mem_req === 1'b0, mem_req, 1'b0);
    chk("illegal", illegal === exp_illegal, illegal, exp_illegal);
    @(negedge clock);
    chk("illegal_pulse", illegal === 1'b0, illegal, 1'b0);
  endtask

  task automatic do_mem(input int waits);
    logic [31:0] v;
    logic        exp_we;
    exp_we = (exp_mem == 1);
    wait_req();
    chk("mem_we", mem_we === exp_we, mem_we, exp_we);
    chk("mem_addr", mem_addr === exp_addr, mem_addr, exp_addr);
    if (exp_mem == 1) chk("mem_wdata", mem_wdata === exp_wdata, mem_wdata, exp_wdata);
    for (int w = 0; w < waits; w++) begin
      @(negedge clock);
      chk("mem_hold_req", mem_req === 1'b1, mem_req, 1'b1);
      chk("mem_hold_addr", mem_addr === exp_addr, mem_addr, exp_addr);
    end
    if (!m_dmem.exists(exp_addr)) m_dmem[exp_addr] = $urandom();
    v         = m_dmem[exp_addr];
    mem_ready = 1'b1;
    mem_rdata = v;
    @(negedge clock);
    mem_ready = 1'b0;
    mem_rdata = $urandom();
    if (exp_mem == 2) m_r[ld_rd] = v;
  endtask

  task automatic step(input logic [31:0] ins, input int waits);
    fetch(ins, waits);
    if (exp_mem != 0) begin
      do_mem(int'($urandom_range(0, 2)));
    end else if (exp_halt) begin
      for (int i = 0; i < 4; i++) begin
        chk("halt_flag", halted === 1'b1, halted, 1'b1);
        chk("halt_req", mem_req === 1'b0, mem_req, 1'b0);
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
      mem_ready = 1'b0;
    end
  endtask

  // Reveal every register through ST and every flag through BRF
  task automatic sweep();
    for (int i = 0; i < 8; i++) step(enc(7, 0, i, i, 0, 0), 0);
    for (int i = 0; i < 8; i++) step(enc(10, 0, i, 0, 0, 'h100 + 4 * i), 0);
  endtask

  initial begin
    int sel;
    int op;
    reset     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    do_reset();

    // Subtraction with and without borrow
    step(enc(6, 1, 0, 0, 0, 'h0005), 0);
    step(enc(6, 2, 0, 0, 0, 'h0003), 0);
    step(enc(2, 3, 1, 2, 0, 0), 0);
    step(enc(7, 0, 3, 3, 0, 0), 0);
    step(enc(10, 0, 3, 0, 0, 'h0050), 0);
    step(enc(2, 3, 2, 1, 0, 0), 0);
    step(enc(7, 0, 3, 3, 0, 0), 0);
    step(enc(10, 0, 3, 0, 0, 'h0060), 0);

    // Fetch wait states, then one store and load round trip
    step(enc(6, 1, 0, 0, 0, 'h0040), 3);
    step(enc(6, 2, 0, 0, 0, 'hDEAD), 0);
    step(enc(7, 0, 1, 2, 0, 0), 0);
    step(enc(8, 5, 1, 0, 0, 0), 0);
    step(enc(7, 0, 1, 5, 0, 0), 0);

    // Flag compare then branch, taken and not taken
    step(enc(6, 6, 0, 0, 0, 7), 0);
    step(enc(6, 7, 0, 0, 0, 7), 0);
    step(enc(11, 4, 6, 7, 0, 0), 0);
    step(enc(10, 0, 4, 0, 0, 'h0020), 0);
    step(enc(11, 4, 6, 1, 0, 0), 0);
    step(enc(10, 0, 4, 0, 0, 'h0020), 0);

    // Undefined opcode behaves as NOP
    step(enc(6'h3E, 3, 1, 2, 1, 'hFFFF), 1);
    sweep();

    // Random instruction stream
    for (int k = 0; k < 250; k++) begin
      sel = int'($urandom_range(0, 15));
      if (sel == 14) op = int'($urandom_range(14, 62));
      else if (sel == 15) op = 6;
      else op = sel;
      step(enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 65535))), int'($urandom_range(0, 2)));
    end
    sweep();

    // Reset while a load is stalled; a late ready must not be taken
    fetch(enc(8, 3, 1, 0, 0, 0), 0);
    chk("mid_mem_req", mem_req === 1'b1, mem_req, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_abandon_req", mem_req === 1'b0, mem_req, 1'b0);
    mem_ready = 1'b1;
    reset     = 1'b1;
    model_reset();
    @(negedge clock);
    mem_ready = 1'b0;
    step(enc(6, 1, 0, 0, 1, 'h1234), 0);
    step(enc(7, 0, 1, 1, 0, 0), 0);

    // Halt is sticky until reset
    step(enc(63, 0, 0, 0, 0, 0), 0);
    do_reset();
    step(enc(0, 0, 0, 0, 0, 0), 0);
    step(enc(7, 0, 2, 3, 0, 0), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
